// File: rtl/mem_wb.sv
// MEM/WB pipeline register: aligns and extends load data, applies flush/stall, owns HI/LO.
// Latency 1 cycle MEM->WB; HI/LO commit on the following edge and are forwarded in the meantime.
module mem_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
  output logic              wb_wreg,
  output logic [ADDR_W-1:0] wb_wd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              adel_o
);

  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;
  localparam logic [2:0] LD_LW  = 3'd5;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_wdata;
  logic              w_misaligned;

  logic              r_wreg;
  logic [ADDR_W-1:0] r_wd;
  logic [DATA_W-1:0] r_wdata;
  logic              r_adel;
  logic              r_whilo;
  logic              r_fresh;
  logic [DATA_W-1:0] r_hi_new;
  logic [DATA_W-1:0] r_lo_new;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    w_byte = 8'h00;
    case (mem_addr_lo)
      2'd0:    w_byte = mem_rdata[31:24];
      2'd1:    w_byte = mem_rdata[23:16];
      2'd2:    w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  always_comb begin
    w_wdata      = mem_wdata;
    w_misaligned = 1'b0;
    case (mem_load)
      LD_LB:  w_wdata = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_LBU: w_wdata = {{(DATA_W-8){1'b0}}, w_byte};
      LD_LH: begin
        w_wdata      = {{(DATA_W-16){w_half[15]}}, w_half};
        w_misaligned = mem_addr_lo[0];
      end
      LD_LHU: begin
        w_wdata      = {{(DATA_W-16){1'b0}}, w_half};
        w_misaligned = mem_addr_lo[0];
      end
      LD_LW: begin
        w_wdata      = mem_rdata;
        w_misaligned = |mem_addr_lo;
      end
      default: w_wdata = mem_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wreg   <= 1'b0;
      r_wd     <= '0;
      r_wdata  <= '0;
      r_adel   <= 1'b0;
      r_whilo  <= 1'b0;
      r_fresh  <= 1'b0;
      r_hi_new <= '0;
      r_lo_new <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      // Commit only on the edge right after the entry was captured.
      if (r_fresh && r_whilo) begin
        r_hi <= r_hi_new;
        r_lo <= r_lo_new;
      end
      if (flush || (stall_mem && !stall_wb)) begin
        r_wreg   <= 1'b0;
        r_wd     <= '0;
        r_wdata  <= '0;
        r_adel   <= 1'b0;
        r_whilo  <= 1'b0;
        r_fresh  <= 1'b0;
        r_hi_new <= '0;
        r_lo_new <= '0;
      end else if (stall_mem) begin
        r_adel  <= 1'b0;
        r_fresh <= 1'b0;
      end else begin
        r_wreg   <= mem_wreg && !w_misaligned;
        r_wd     <= mem_wd;
        r_wdata  <= w_wdata;
        r_adel   <= w_misaligned;
        r_whilo  <= mem_whilo;
        r_fresh  <= 1'b1;
        r_hi_new <= mem_hi;
        r_lo_new <= mem_lo;
      end
    end
  end

  assign wb_wreg  = r_wreg;
  assign wb_wd    = r_wd;
  assign wb_wdata = r_wdata;
  assign adel_o   = r_adel;
  assign hi_o     = r_whilo ? r_hi_new : r_hi;
  assign lo_o     = r_whilo ? r_lo_new : r_lo;

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: directed scenarios plus randomized traffic against a rule-level model.
module tb_mem_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_mem, stall_wb, flush;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_load;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic [31:0] hi_o, lo_o;
  logic        adel_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the WB entry as the rules describe it.
  logic        e_wreg, e_adel, e_whilo, e_fresh, e_data_known;
  logic [4:0]  e_wd;
  logic [31:0] e_wdata, e_hi_new, e_lo_new, m_hi, m_lo;

  mem_wb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_load(mem_load),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .wb_wreg(wb_wreg), .wb_wd(wb_wd),
    .wb_wdata(wb_wdata), .hi_o(hi_o), .lo_o(lo_o), .adel_o(adel_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] load_value(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] rd, input logic [31:0] alu);
    logic [31:0] b, h;
    b = (rd >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
    h = (rd >> (off[1] ? 0 : 16)) & 32'h0000_FFFF;
    case (t)
      3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      3'd5:    return rd;
      default: return alu;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
    return ((t == 3'd3 || t == 3'd4) && (off % 2 == 1)) || (t == 3'd5 && off != 2'd0);
  endfunction

  task automatic model_reset();
    e_wreg = 0; e_wd = 0; e_wdata = 0; e_adel = 0; e_whilo = 0; e_fresh = 0;
    e_data_known = 1; e_hi_new = 0; e_lo_new = 0; m_hi = 0; m_lo = 0;
  endtask

  // Advance the model by one edge using the present inputs, then step the DUT.
  task automatic tick();
    if (e_fresh && e_whilo) begin
      m_hi = e_hi_new;
      m_lo = e_lo_new;
    end
    if (flush || (stall_mem && !stall_wb)) begin
      e_wreg = 0; e_wd = 0; e_wdata = 0; e_adel = 0; e_whilo = 0; e_fresh = 0;
      e_data_known = 1;
    end else if (stall_mem && stall_wb) begin
      e_adel = 0; e_fresh = 0;
    end else begin
      e_adel       = is_misaligned(mem_load, mem_addr_lo);
      e_wreg       = mem_wreg && !e_adel;
      e_wd         = mem_wd;
      e_wdata      = load_value(mem_load, mem_addr_lo, mem_rdata, mem_wdata);
      e_data_known = !e_adel;
      e_whilo      = mem_whilo;
      e_hi_new     = mem_hi;
      e_lo_new     = mem_lo;
      e_fresh      = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic wr, input logic [4:0] wd, input logic [31:0] alu,
                        input logic [2:0] ld, input logic [1:0] off, input logic [31:0] rd,
                        input logic whl, input logic [31:0] hi, input logic [31:0] lo);
    mem_wreg = wr; mem_wd = wd; mem_wdata = alu; mem_load = ld; mem_addr_lo = off;
    mem_rdata = rd; mem_whilo = whl; mem_hi = hi; mem_lo = lo;
  endtask

  task automatic set_ctl(input logic sm, input logic sw, input logic fl);
    stall_mem = sm; stall_wb = sw; flush = fl;
  endtask

  task automatic test_reset();
    rst = 0;
    set_ctl(0, 0, 0);
    set_in(1, 5'd9, 32'h1111_2222, 3'd0, 2'd0, 32'h0, 1, 32'h5, 32'h6);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({wb_wreg, wb_wd, wb_wdata, hi_o, lo_o, adel_o} !== 103'd0) begin
      n_fail++;
      $display("FAIL reset_state got wreg=%0b wd=%0d wdata=%h hi=%h lo=%h adel=%0b required all zero",
               wb_wreg, wb_wd, wb_wdata, hi_o, lo_o, adel_o);
    end
    rst = 1;
    set_ctl(0, 0, 1);
    tick();
    n_checks++;
    if (wb_wreg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flush_first got wreg=%0b required 0", wb_wreg);
    end
    set_ctl(0, 0, 0);
    tick();
    n_checks++;
    if ({wb_wreg, wb_wd, wb_wdata} !== {1'b1, 5'd9, 32'h1111_2222}) begin
      n_fail++;
      $display("FAIL reset_first_capture got %0b/%0d/%h required 1/9/11112222", wb_wreg, wb_wd, wb_wdata);
    end
  endtask

  task automatic test_loads();
    set_ctl(0, 0, 0);
    set_in(1, 5'd3, 32'h0, 3'd1, 2'd1, 32'h12F4_5678, 0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if ({wb_wreg, wb_wd, wb_wdata, adel_o} !== {1'b1, 5'd3, 32'hFFFF_FFF4, 1'b0}) begin
      n_fail++;
      $display("FAIL lb_off1 got %0b/%0d/%h adel=%0b required 1/3/fffffff4 adel=0", wb_wreg, wb_wd, wb_wdata, adel_o);
    end
    set_in(1, 5'd4, 32'h0, 3'd4, 2'd2, 32'h1234_ABCD, 0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if ({wb_wreg, wb_wdata} !== {1'b1, 32'h0000_ABCD}) begin
      n_fail++;
      $display("FAIL lhu_off2 got %0b/%h required 1/0000abcd", wb_wreg, wb_wdata);
    end
    set_in(1, 5'd4, 32'h0, 3'd3, 2'd1, 32'h1234_ABCD, 0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if ({wb_wreg, adel_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL lh_misaligned got wreg=%0b adel=%0b required wreg=0 adel=1", wb_wreg, adel_o);
    end
    set_ctl(1, 1, 0);
    tick();
    n_checks++;
    if ({wb_wreg, adel_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL adel_one_cycle got wreg=%0b adel=%0b required 0/0", wb_wreg, adel_o);
    end
    set_ctl(0, 0, 0);
    set_in(1, 5'd0, 32'h0, 3'd5, 2'd0, 32'hCAFE_F00D, 0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if ({wb_wreg, wb_wd, wb_wdata} !== {1'b1, 5'd0, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("FAIL lw_to_r0 got %0b/%0d/%h required 1/0/cafef00d", wb_wreg, wb_wd, wb_wdata);
    end
  endtask

  task automatic test_stall_hold();
    set_ctl(0, 0, 0);
    set_in(1, 5'd7, 32'hDEAD_BEEF, 3'd0, 2'd0, 32'h0, 0, 32'h0, 32'h0);
    tick();
    set_ctl(1, 1, 0);
    set_in(1, 5'd12, 32'h0BAD_0BAD, 3'd0, 2'd0, 32'h0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({wb_wreg, wb_wd, wb_wdata} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin
        n_fail++;
        $display("FAIL stall_hold_%0d got %0b/%0d/%h required 1/7/deadbeef", i, wb_wreg, wb_wd, wb_wdata);
      end
    end
    set_ctl(1, 0, 0);
    tick();
    n_checks++;
    if ({wb_wreg, wb_wd, wb_wdata} !== 38'd0) begin
      n_fail++;
      $display("FAIL stall_bubble got %0b/%0d/%h required 0/0/0", wb_wreg, wb_wd, wb_wdata);
    end
  endtask

  task automatic test_flush();
    set_ctl(0, 0, 0);
    set_in(1, 5'd5, 32'h1234_5678, 3'd0, 2'd0, 32'h0, 0, 32'h0, 32'h0);
    tick();
    set_ctl(0, 1, 1);
    set_in(1, 5'd6, 32'h8765_4321, 3'd0, 2'd0, 32'h0, 0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if ({wb_wreg, wb_wd, wb_wdata} !== 38'd0) begin
      n_fail++;
      $display("FAIL flush_over_stall got %0b/%0d/%h required 0/0/0", wb_wreg, wb_wd, wb_wdata);
    end
  endtask

  task automatic test_hilo();
    set_ctl(0, 0, 0);
    set_in(1, 5'd2, 32'h77, 3'd0, 2'd0, 32'h0, 1, 32'hA, 32'hB);
    tick();
    n_checks++;
    if ({hi_o, lo_o, wb_wreg, wb_wdata} !== {32'hA, 32'hB, 1'b1, 32'h77}) begin
      n_fail++;
      $display("FAIL hilo_forward got hi=%h lo=%h wreg=%0b wdata=%h required a/b/1/77", hi_o, lo_o, wb_wreg, wb_wdata);
    end
    set_in(0, 5'd0, 32'h0, 3'd0, 2'd0, 32'h0, 0, 32'h5, 32'h6);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({hi_o, lo_o} !== {32'hA, 32'hB}) begin
        n_fail++;
        $display("FAIL hilo_kept_%0d got hi=%h lo=%h required a/b", i, hi_o, lo_o);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    set_ctl(0, 0, 0);
    set_in(1, 5'd8, 32'h5555_AAAA, 3'd0, 2'd0, 32'h0, 1, 32'h3, 32'h4);
    tick();
    set_ctl(1, 1, 0);
    tick();
    #2 rst = 0;
    #1;
    n_checks++;
    if ({wb_wreg, wb_wd, wb_wdata, hi_o, lo_o, adel_o} !== 103'd0) begin
      n_fail++;
      $display("FAIL reset_mid_hold got wreg=%0b wd=%0d wdata=%h hi=%h lo=%h adel=%0b required all zero",
               wb_wreg, wb_wd, wb_wdata, hi_o, lo_o, adel_o);
    end
    #1 rst = 1;
    model_reset();
    set_ctl(0, 0, 0);
    set_in(1, 5'd1, 32'h0, 3'd2, 2'd3, 32'h0000_0081, 0, 32'h0, 32'h0);
    tick();
    n_checks++;
    if ({wb_wreg, wb_wd, wb_wdata, hi_o} !== {1'b1, 5'd1, 32'h81, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_clean_capture got %0b/%0d/%h hi=%h required 1/1/81 hi=0", wb_wreg, wb_wd, wb_wdata, hi_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_ctl(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      set_in(1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom,
             ($urandom_range(0, 3) == 0), $urandom, $urandom);
      tick();
      n_checks++;
      if ({wb_wreg, wb_wd, adel_o} !== {e_wreg, e_wd, e_adel} ||
          (e_data_known && wb_wdata !== e_wdata) ||
          hi_o !== (e_whilo ? e_hi_new : m_hi) || lo_o !== (e_whilo ? e_lo_new : m_lo)) begin
        n_fail++;
        $display("FAIL random_%0d got %0b/%0d/%h adel=%0b hi=%h lo=%h required %0b/%0d/%h adel=%0b hi=%h lo=%h",
                 i, wb_wreg, wb_wd, wb_wdata, adel_o, hi_o, lo_o, e_wreg, e_wd, e_wdata, e_adel,
                 e_whilo ? e_hi_new : m_hi, e_whilo ? e_lo_new : m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stall_hold();
    test_flush();
    test_hilo();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
